// File: rtl/matrix_io_port.sv
// matrix_io_port: chip-side responder for the matrix accelerator pad protocol.
// Captures 32-byte input matrices, hands each one to the compute core, stores
// the core's 16 results per matrix, and serves host readback as 9-bit halves.
module matrix_io_port #(
  parameter int MATRIX_NUM = 2,
  parameter int X_W        = 8,
  parameter int RES_W      = 18,  // must be 2*OUT_W
  parameter int OUT_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             valid_input,
  input  logic [X_W-1:0]   x_load,
  input  logic             read_n,
  input  logic [7:0]       r_addr,
  output logic             ry,
  output logic [OUT_W-1:0] read_data,
  output logic             finish,
  input  logic [4:0]       x_rd_addr,
  output logic [X_W-1:0]   x_rd_data,
  output logic             core_start,
  input  logic             core_res_we,
  input  logic [3:0]       core_res_addr,
  input  logic [RES_W-1:0] core_res_data,
  input  logic             core_done
);
  localparam int DEPTH = MATRIX_NUM * 16;
  localparam int RAW   = $clog2(DEPTH);
  // m_idx must be able to hold MATRIX_NUM once the batch completes
  localparam int MW    = $clog2(MATRIX_NUM + 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WAIT_NEXT, ALL_DONE} st_t;
  typedef enum logic [1:0] {R_IDLE, R_MEM, R_LO, R_HI} rd_st_t;

  st_t              st, st_nx;
  rd_st_t           rs, rs_nx;
  logic [4:0]       bcnt;
  logic [MW-1:0]    m_idx;
  logic [X_W-1:0]   xbuf [32];
  logic [RES_W-1:0] res_mem [DEPTH];
  logic [7:0]       addr_q;
  logic [RES_W-1:0] word_q;

  logic           load_beat, last_beat, res_wr, rd_acc, enter_load;
  logic [RAW-1:0] wr_idx;

  assign load_beat  = (st == LOAD) && valid_input;
  assign last_beat  = load_beat && (bcnt == 5'd31);
  assign res_wr     = (st == COMPUTE) && core_res_we;
  assign enter_load = (st_nx == LOAD) && (st != LOAD);
  assign rd_acc     = ry && !read_n;
  assign wr_idx     = RAW'({m_idx, 4'b0000}) + RAW'(core_res_addr);
  assign x_rd_data  = xbuf[x_rd_addr];

  // main FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else      st <= st_nx;

  // main FSM next state; a same-cycle result write lands before COMPUTE exits
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:                if (start_in)  st_nx = LOAD;
      LOAD:                if (last_beat) st_nx = COMPUTE;
      COMPUTE:             if (core_done)
                             st_nx = (int'(m_idx) + 1 < MATRIX_NUM) ? WAIT_NEXT : ALL_DONE;
      WAIT_NEXT, ALL_DONE: if (start_in)  st_nx = LOAD;
      default:             st_nx = IDLE;
    endcase
  end

  // main FSM outputs; host reads only while the core is not touching memory
  always_comb begin
    finish = (st == WAIT_NEXT) || (st == ALL_DONE);
    ry     = ((st == IDLE) || (st == WAIT_NEXT) || (st == ALL_DONE)) && (rs == R_IDLE);
  end

  // byte counter, matrix index, and the one-cycle core start pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bcnt       <= '0;
      m_idx      <= '0;
      core_start <= 1'b0;
    end else begin
      core_start <= last_beat;
      if (enter_load)     bcnt <= '0;
      else if (load_beat) bcnt <= bcnt + 5'd1;
      if ((st == ALL_DONE) && start_in)     m_idx <= '0;
      else if ((st == COMPUTE) && core_done) m_idx <= m_idx + 1'b1;
    end

  // input buffer and result memory; contents survive reset
  always_ff @(posedge clk) begin
    if (load_beat) xbuf[bcnt]      <= x_load;
    if (res_wr)    res_mem[wr_idx] <= core_res_data;
  end

  // read FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) rs <= R_IDLE;
    else      rs <= rs_nx;

  // read FSM next state: fixed four-step walk once a request is accepted
  always_comb begin
    rs_nx = rs;
    case (rs)
      R_IDLE:  if (rd_acc) rs_nx = R_MEM;
      R_MEM:   rs_nx = R_LO;
      R_LO:    rs_nx = R_HI;
      R_HI:    rs_nx = R_IDLE;
      default: rs_nx = R_IDLE;
    endcase
  end

  // read datapath: latch address, fetch word (zero if out of range), emit halves
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q    <= '0;
      word_q    <= '0;
      read_data <= '0;
    end else begin
      case (rs)
        R_IDLE: if (rd_acc) addr_q <= r_addr;
        R_MEM:  word_q    <= ({1'b0, addr_q} < 9'(DEPTH)) ? res_mem[addr_q[RAW-1:0]] : '0;
        R_LO:   read_data <= word_q[OUT_W-1:0];
        R_HI:   read_data <= word_q[RES_W-1:OUT_W];
        default: ;
      endcase
    end
endmodule

// File: tb/tb_matrix_io_port.sv
// tb_matrix_io_port: directed stimulus with a timed scoreboard. Stimulus pushes
// expected core_start cycles and read_data halves; a negedge monitor pops them.
module tb_matrix_io_port;
  localparam int MATRIX_NUM = 2, X_W = 8, RES_W = 18, OUT_W = 9;

  logic             clk = 1'b0, rst = 1'b0;
  logic             start_in = 0, valid_input = 0, read_n = 1;
  logic [X_W-1:0]   x_load = '0;
  logic [7:0]       r_addr = '0;
  logic             ry, finish, core_start;
  logic [OUT_W-1:0] read_data;
  logic [4:0]       x_rd_addr = '0;
  logic [X_W-1:0]   x_rd_data;
  logic             core_res_we = 0, core_done = 0;
  logic [3:0]       core_res_addr = '0;
  logic [RES_W-1:0] core_res_data = '0;

  matrix_io_port #(.MATRIX_NUM(MATRIX_NUM), .X_W(X_W), .RES_W(RES_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .valid_input(valid_input), .x_load(x_load),
    .read_n(read_n), .r_addr(r_addr), .ry(ry), .read_data(read_data), .finish(finish),
    .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data), .core_start(core_start),
    .core_res_we(core_res_we), .core_res_addr(core_res_addr),
    .core_res_data(core_res_data), .core_done(core_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct { int due; logic [OUT_W-1:0] val; } rd_exp_t;
  rd_exp_t          rd_q[$];
  int               st_q[$];
  logic [OUT_W-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compare core_start pulses and read_data against queued expectations
  always @(negedge clk) begin
    if (core_start) begin
      if (st_q.size() == 0) begin
        total++; bad++;
        $display("FAIL core_start: unexpected pulse at cycle %0d, expected none", cyc);
      end else chk("core_start cycle", cyc, st_q.pop_front());
    end
    while (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      chk("read_data", read_data, rd_q[0].val);
      void'(rd_q.pop_front());
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_start();
    start_in = 1; tick(); start_in = 0;
  endtask

  task automatic load(input logic [7:0] base, input int gap_after, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      valid_input = 1; x_load = 8'(base + k); tick();
      if (k == 31) st_q.push_back(cyc);
      valid_input = 0;
      if (k == gap_after) repeat (3) tick();
    end
  endtask

  task automatic xchk(input logic [4:0] a, input logic [7:0] exp);
    x_rd_addr = a; #1;
    chk("x_rd_data", x_rd_data, exp);
  endtask

  task automatic core_wr(input logic [3:0] a, input logic [17:0] d, input logic done);
    core_res_we = 1; core_res_addr = a; core_res_data = d; core_done = done; tick();
    core_res_we = 0; core_done = 0;
  endtask

  task automatic core_fin();
    core_done = 1; tick(); core_done = 0;
  endtask

  // accepted read; optional second request one cycle later that must be dropped
  task automatic rd(input logic [7:0] a, input logic [8:0] lo, input logic [8:0] hi, input logic twice);
    rd_exp_t e;
    read_n = 0; r_addr = a; tick();
    e.due = cyc + 2; e.val = lo; rd_q.push_back(e);
    e.due = cyc + 3; e.val = hi; rd_q.push_back(e);
    if (twice) begin r_addr = a ^ 8'h01; tick(); end
    read_n = 1;
    chk("ry low during read", ry, 0);
    repeat (twice ? 2 : 3) tick();
    chk("ry back high", ry, 1);
    last_rd = hi;
  endtask

  // request while not ready: read_data must keep its last value
  task automatic rd_drop(input logic [7:0] a);
    rd_exp_t e;
    read_n = 0; r_addr = a; tick(); read_n = 1;
    e.due = cyc + 2; e.val = last_rd; rd_q.push_back(e);
    e.due = cyc + 3; e.val = last_rd; rd_q.push_back(e);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("reset ry", ry, 1);
    chk("reset read_data", read_data, 0);
    chk("reset finish", finish, 0);
    chk("reset core_start", core_start, 0);
    rst = 1; tick();

    // matrix 0: contiguous load 0x00..0x1F
    do_start();
    chk("ry in LOAD", ry, 0);
    load(8'h00, -1, 32);
    xchk(5'd0, 8'h00); xchk(5'd17, 8'h11); xchk(5'd31, 8'h1F);
    for (int i = 0; i < 16; i++) core_wr(4'(i), 18'(18'h3FFFF - i), 1'b0);
    chk("finish before done", finish, 0);
    core_fin();
    chk("finish after m0", finish, 1);
    chk("ry after m0", ry, 1);
    rd(8'd5, 9'h1FA, 9'h1FF, 1'b1);
    rd(8'd15, 9'h1F0, 9'h1FF, 1'b0);

    // matrix 1: gapped load, dropped reads in LOAD and COMPUTE, write+done together
    do_start();
    chk("finish falls on start", finish, 0);
    rd_drop(8'd5);
    load(8'h40, 10, 32);
    xchk(5'd10, 8'h4A); xchk(5'd11, 8'h4B); xchk(5'd31, 8'h5F);
    rd_drop(8'd5);
    for (int i = 0; i < 15; i++) core_wr(4'(i), 18'((i << 9) | (256 + i)), 1'b0);
    core_wr(4'd15, 18'h01F0F, 1'b1);
    chk("finish at ALL_DONE", finish, 1);
    core_wr(4'd0, 18'h12345, 1'b1);  // ignored outside COMPUTE
    chk("finish held in ALL_DONE", finish, 1);
    rd(8'd40, 9'h000, 9'h000, 1'b0);
    rd(8'd19, 9'h103, 9'h003, 1'b0);
    rd(8'd31, 9'h10F, 9'h00F, 1'b0);
    rd(8'd0,  9'h1FF, 9'h1FF, 1'b0);

    // new batch, aborted by reset at byte 20
    do_start();
    load(8'h80, -1, 20);
    rst = 0; #1;
    chk("mid-load reset finish", finish, 0);
    chk("mid-load reset ry", ry, 1);
    chk("mid-load reset read_data", read_data, 0);
    chk("mid-load reset core_start", core_start, 0);
    last_rd = '0;
    tick(); rst = 1; tick();

    // reload from bcnt=0, m_idx=0
    do_start();
    load(8'hC0, -1, 32);
    xchk(5'd0, 8'hC0); xchk(5'd20, 8'hD4); xchk(5'd31, 8'hDF);
    core_wr(4'd2, 18'h2AAAA, 1'b0);
    core_fin();
    chk("finish after restart", finish, 1);
    rd(8'd2,  9'h0AA, 9'h155, 1'b0);
    rd(8'd18, 9'h102, 9'h002, 1'b0);

    repeat (4) tick();
    chk("pending expectations", st_q.size() + rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_io_port.md
# matrix_io_port

Chip-side responder for the matrix accelerator's pad protocol. It captures `MATRIX_NUM` input matrices of 32 bytes each, streamed in by the host via `start_in`/`valid_input`/`x_load`. It hands each matrix to the compute core and stores the core's 16 results of 18 bits per matrix. It then serves host readback through `r_addr`/`read_n`, returning each result as two 9-bit halves on `read_data`. The block sits between the pad ring and the compute core, inside the chip top.

## Interface
- `MATRIX_NUM`, 2: matrices per batch; result memory depth is `MATRIX_NUM*16`.
- `X_W`, 8: input byte width.
- `RES_W`, 18: result word width; must equal `2*OUT_W`.
- `OUT_W`, 9: read port width.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start_in`, in, 1: host request to begin loading one matrix.
- `valid_input`, in, 1: `x_load` carries a valid byte this cycle.
- `x_load`, in, `X_W`: input byte.
- `read_n`, in, 1: active-low read request, one cycle wide.
- `r_addr`, in, 8: result index to read.
- `ry`, out, 1: ready; high means a read request will be accepted.
- `read_data`, out, `OUT_W`: readback data.
- `finish`, out, 1: current matrix is computed; the host may start the next matrix.
- `x_rd_addr`, in, 5: core read address into the current input buffer.
- `x_rd_data`, out, `X_W`: combinational buffer read for `x_rd_addr`.
- `core_start`, out, 1: one-cycle pulse that starts the core.
- `core_res_we`, in, 1: core result write strobe.
- `core_res_addr`, in, 4: result index within the current matrix.
- `core_res_data`, in, `RES_W`: result word.
- `core_done`, in, 1: one-cycle pulse; the core has finished the current matrix.

## Operation
- Main FSM states: `IDLE`, `LOAD`, `COMPUTE`, `WAIT_NEXT`, `ALL_DONE`.
  - `IDLE` → `LOAD` on `start_in`; clears byte counter `bcnt`.
  - `LOAD`: each cycle with `valid_input`=1 writes `x_load` to `buf[bcnt]` and increments `bcnt`. Gaps, i.e. cycles with `valid_input`=0, are allowed.
  - When the 32nd byte is written (`bcnt`==31), go to `COMPUTE` and pulse `core_start` in the following cycle.
  - `COMPUTE`: each `core_res_we` writes `core_res_data` to `res_mem[m_idx*16 + core_res_addr]`. On `core_done`, increment `m_idx`. Then go to `WAIT_NEXT` if `m_idx+1 < MATRIX_NUM`, otherwise go to `ALL_DONE`.
  - `WAIT_NEXT` → `LOAD` on `start_in`.
  - `ALL_DONE` → `LOAD` on `start_in`; `m_idx` is cleared to 0 (new batch).
- `finish` is high in `WAIT_NEXT` and `ALL_DONE`, and low in every other state.
- Ignored inputs:
  - `start_in` in `LOAD`/`COMPUTE`.
  - `valid_input` outside `LOAD`.
  - `core_res_we`/`core_done` outside `COMPUTE`.
- `core_res_we` and `core_done` in the same cycle: the write completes, then the state transition happens.
- Read FSM states: `R_IDLE`, `R_MEM`, `R_LO`, `R_HI`. It runs independently of the main FSM.
  - `ry` = (main state ∈ {`IDLE`, `WAIT_NEXT`, `ALL_DONE`}) && read state == `R_IDLE`.
  - `read_n`=0 sampled while `ry`=1: latch `r_addr` and go to `R_MEM`. Otherwise the request is dropped.
  - `R_MEM`: register `res_mem[addr]`; if `addr >= MATRIX_NUM*16` the registered word is 0.
  - `R_LO`: `read_data` <= word[8:0].
  - `R_HI`: `read_data` <= word[17:9]; return to `R_IDLE`.
  - `read_data` holds its last value until the next read.
- Reset:
  - Outputs: `ry`=1, `read_data`=0, `finish`=0, `core_start`=0.
  - State: both FSMs idle, `m_idx`=0, `bcnt`=0.
  - Buffer and result memory are not cleared.
  - Reset mid-load or mid-read aborts the operation with no partial output.

## Timing
- Load: byte k written at the edge where it is sampled with `valid_input`. `core_start` is high for exactly the cycle after the edge that writes byte 31.
- `finish` rises the cycle after the edge that samples `core_done`. It falls the cycle after the edge that samples `start_in`.
- Read, with T = the edge sampling `read_n`=0:
  - `ry` falls after T.
  - Low half appears on `read_data` after edge T+2.
  - High half appears after edge T+3.
  - `ry` rises after edge T+3, so the next request can be sampled at T+4.
- `x_rd_data` is combinational from `buf`; a write at edge E is visible after E.

## Test plan
- Reset, then `start_in` followed by 32 consecutive beats of 0x00..0x1F → `buf[k]`=k; one `core_start` pulse one cycle after the last beat; `ry`=0 during `LOAD`.
- Load with `valid_input` gaps (e.g. 3 idle cycles after byte 10) → still exactly 32 bytes captured; `core_start` timing is relative to the 32nd beat.
- Core writes 16 results 0x3FFFF−i for matrix 0, then `core_done` → `finish`=1. Read `r_addr`=5 → low half 0x1FA, then high half 0x1FF, at T+2/T+3.
- Full batch, `MATRIX_NUM`=2 → results land at indices 16..31; state reaches `ALL_DONE`. Reading `r_addr`=40 returns 0, 0.
- `read_n` pulses during `LOAD`/`COMPUTE`, and a second pulse at T+1 → both dropped; `read_data` unchanged.
- Assert `rst` mid-load at byte 20 → `finish`=0, `ry`=1. A following load restarts at `bcnt`=0 with `m_idx`=0.
